// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider with a single valid/ready config slot.
// Optional CLK_DIV_SYNC_EN adds a `sync` input that restarts every channel in phase.
module clk_divider_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 24,
  parameter int CLK_HZ   = 100_000_000,
  parameter int FREQ     = 100,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk100MHz,
  input  logic                rst_n,
`ifdef CLK_DIV_SYNC_EN
  input  logic                sync,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_half,
  output logic [CHANNELS-1:0] clk_div,
  output logic [CHANNELS-1:0] tick
);

  localparam longint DEFAULT_HALF = longint'(CLK_HZ) / 2 / longint'(FREQ);

  if (DEFAULT_HALF == 0 || (DEFAULT_HALF >> WIDTH) != 0) begin : g_bad_default
    $error("clk_divider_multi: DEFAULT_HALF must be nonzero and fit in WIDTH bits");
  end

  logic [WIDTH-1:0]    half  [CHANNELS];
  logic [WIDTH-1:0]    count [CHANNELS];
  logic                pend_v;
  logic [CH_W-1:0]     pend_ch;
  logic [WIDTH-1:0]    pend_half;

  logic                sync_i;
  logic                pend_known;
  logic                apply;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] disabled;
  logic [CHANNELS-1:0] hit;

`ifdef CLK_DIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  assign cfg_ready = !pend_v;

  // A pending entry retires when its target can take it: disabled, wrapping, or
  // being restarted by sync. Entries for nonexistent channels retire at once.
  always_comb begin
    wrap       = '0;
    disabled   = '0;
    hit        = '0;
    pend_known = int'(pend_ch) < CHANNELS;
    for (int c = 0; c < CHANNELS; c++) begin
      disabled[c] = (half[c] == '0);
      wrap[c]     = !disabled[c] && (count[c] == half[c] - 1'b1);
      hit[c]      = pend_v && (pend_ch == CH_W'(c));
    end
    apply = (|(hit & (wrap | disabled | {CHANNELS{sync_i}}))) || (pend_v && !pend_known);
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_ch   <= '0;
      pend_half <= '0;
    end else if (cfg_valid && !pend_v) begin
      pend_v    <= 1'b1;
      pend_ch   <= cfg_ch;
      pend_half <= cfg_half;
    end else if (apply) begin
      pend_v    <= 1'b0;
    end
  end

  // NOTE: half/count are small per-channel register arrays, not RAM, so resetting
  // them here is intended and maps to plain flops.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        half[c]    <= WIDTH'(DEFAULT_HALF);
        count[c]   <= '0;
        clk_div[c] <= 1'b0;
        tick[c]    <= 1'b0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync_i || disabled[c]) begin
          count[c]   <= '0;
          clk_div[c] <= 1'b0;
          tick[c]    <= 1'b0;
          if (hit[c]) half[c] <= pend_half;
        end else if (wrap[c]) begin
          count[c] <= '0;
          if (hit[c]) half[c] <= pend_half;
          // Reloading to zero parks the output low instead of toggling.
          if (hit[c] && pend_half == '0) begin
            clk_div[c] <= 1'b0;
            tick[c]    <= 1'b0;
          end else begin
            clk_div[c] <= !clk_div[c];
            tick[c]    <= !clk_div[c];
          end
        end else begin
          count[c] <= count[c] + 1'b1;
          tick[c]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi (CLK_HZ=100, FREQ=10 -> DEFAULT_HALF=5, WIDTH=8).
// Three channels so that cfg_ch=3 is a genuinely out-of-range target on a 2-bit channel field.
module tb_clk_divider_multi;

  localparam int CHANNELS = 3;
  localparam int WIDTH    = 8;
  localparam int CH_W     = 2;

  logic                clk100MHz;
  logic                rst_n;
  logic                sync;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [WIDTH-1:0]    cfg_half;
  logic [CHANNELS-1:0] clk_div;
  logic [CHANNELS-1:0] tick;

  int total = 0;
  int bad   = 0;

  clk_divider_multi #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .CLK_HZ  (100),
    .FREQ    (10)
  ) dut (
    .clk100MHz(clk100MHz),
    .rst_n    (rst_n),
`ifdef CLK_DIV_SYNC_EN
    .sync     (sync),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .clk_div  (clk_div),
    .tick     (tick)
  );

  initial clk100MHz = 1'b0;
  always #5 clk100MHz = ~clk100MHz;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk100MHz);
    #1;
  endtask

  task automatic outs(input string tag, input logic [2:0] exp_div, input logic [2:0] exp_tick);
    check({tag, ".clk_div"}, 32'(clk_div), 32'(exp_div));
    check({tag, ".tick"},    32'(tick),    32'(exp_tick));
  endtask

  // Leaves the bench at a falling edge with reset released; the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk100MHz);
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    @(posedge clk100MHz);
    @(negedge clk100MHz);
    rst_n = 1'b1;
  endtask

  task automatic cfg(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] h);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = h;
  endtask

  initial begin
    rst_n     = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;

    // Reset state
    #12;
    outs("rst", 3'b000, 3'b000);
    check("rst.cfg_ready", 32'(cfg_ready), 32'd1);

    // Reset release: rise at edge 5 with tick, fall at 10, rise again at 15
    do_reset();
    step(4);  outs("e4",  3'b000, 3'b000);
    step(1);  outs("e5",  3'b111, 3'b111);
    step(1);  outs("e6",  3'b111, 3'b000);
    step(3);  outs("e9",  3'b111, 3'b000);
    step(1);  outs("e10", 3'b000, 3'b000);
    step(5);  outs("e15", 3'b111, 3'b111);

    // ch1 half=2 accepted at edge 3, applied on ch1's wrap at edge 5
    do_reset();
    step(2);
    check("w1.ready_before", 32'(cfg_ready), 32'd1);
    cfg(2'd1, 8'd2);
    step(1);
    check("w1.ready_pending", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step(1);  check("w1.e4_ready", 32'(cfg_ready), 32'd0);
    outs("w1.e4", 3'b000, 3'b000);
    step(1);  check("w1.e5_ready", 32'(cfg_ready), 32'd1);
    outs("w1.e5", 3'b111, 3'b111);
    step(2);  outs("w1.e7",  3'b101, 3'b000);
    step(2);  outs("w1.e9",  3'b111, 3'b010);
    step(1);  outs("w1.e10", 3'b010, 3'b000);
    step(1);  outs("w1.e11", 3'b000, 3'b000);
    step(2);  outs("w1.e13", 3'b010, 3'b010);

    // ch0 half=0 applied at its wrap (edge 5): stays low, no tick
    do_reset();
    step(1);
    cfg(2'd0, 8'd0);
    step(1);
    cfg_valid = 1'b0;
    step(3);  outs("d0.e5", 3'b110, 3'b110);
    check("d0.e5_ready", 32'(cfg_ready), 32'd1);
    step(5);  outs("d0.e10", 3'b000, 3'b000);
    step(5);  outs("d0.e15", 3'b110, 3'b110);
    // ch0 half=1 into a disabled channel: 1-cycle apply, then toggles every cycle
    cfg(2'd0, 8'd1);
    step(1);
    check("h1.e16_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step(1);  check("h1.e17_ready", 32'(cfg_ready), 32'd1);
    outs("h1.e17", 3'b110, 3'b000);
    step(1);  outs("h1.e18", 3'b111, 3'b001);
    step(1);  outs("h1.e19", 3'b110, 3'b000);
    step(1);  outs("h1.e20", 3'b001, 3'b001);

    // Out-of-range channel: accepted at edge 21, dropped at edge 22, nothing disturbed
    cfg(2'd3, 8'd2);
    step(1);  check("oor.e21_ready", 32'(cfg_ready), 32'd0);
    step(1);  check("oor.e22_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    outs("oor.e22", 3'b001, 3'b001);
    step(3);  outs("oor.e25", 3'b110, 3'b110);

    // Async reset mid-run with an entry pending
    do_reset();
    step(5);
    cfg(2'd1, 8'd2);
    step(1);
    check("ar.pending", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step(1);  outs("ar.e7", 3'b111, 3'b000);
    @(negedge clk100MHz);
    rst_n = 1'b0;
    #1;
    outs("ar.low", 3'b000, 3'b000);
    check("ar.ready", 32'(cfg_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    step(4);  outs("ar.e4",  3'b000, 3'b000);
    step(1);  outs("ar.e5",  3'b111, 3'b111);
    step(5);  outs("ar.e10", 3'b000, 3'b000);
    step(5);  outs("ar.e15", 3'b111, 3'b111);

`ifdef CLK_DIV_SYNC_EN
    // Misalign ch1 (half 3, then back to 5 mid-phase), then sync restarts everything together
    do_reset();
    cfg(2'd1, 8'd3);
    step(1);
    cfg_valid = 1'b0;
    step(4);  outs("sy.e5", 3'b111, 3'b111);
    cfg(2'd1, 8'd5);
    step(1);
    cfg_valid = 1'b0;
    step(2);  outs("sy.e8", 3'b101, 3'b000);
    check("sy.e8_ready", 32'(cfg_ready), 32'd1);
    step(3);  outs("sy.e11", 3'b000, 3'b000);
    sync = 1'b1;
    step(1);  sync = 1'b0;
    outs("sy.e12", 3'b000, 3'b000);
    step(1);  outs("sy.e13", 3'b000, 3'b000);
    step(3);  outs("sy.e16", 3'b000, 3'b000);
    step(1);  outs("sy.e17", 3'b111, 3'b111);
    step(5);  outs("sy.e22", 3'b000, 3'b000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
